// File: rtl/axi_slave_mem.sv
// AXI-style responder backing a 16 x 32-bit register memory at BASE_ADDR.
// Independent write (AW/W/B) and read (AR/R) FSMs with registered outputs.
module axi_slave_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h1010_1000,
  parameter int          RD_BEATS  = 4
) (
  input  logic         ACLK_i,
  input  logic         ARESET_i,
  // write address channel
  input  logic [31:0]  AWADDR_i,
  input  logic         AWVALID_i,
  input  logic [3:0]   AWID_i,
  output logic         AWREADY_o,
  // write data channel
  input  logic [31:0]  WDATA_i,
  input  logic         WVALID_i,
  input  logic         WLAST_i,
  input  logic [3:0]   WLEN_i,
  input  logic [2:0]   WSIZE_i,
  output logic         WREADY_o,
  // write response channel
  output logic         BVALID_o,
  output logic [1:0]   BRESP_o,
  output logic [3:0]   BID_o,
  input  logic         BREADY_i,
  // read address channel
  input  logic [31:0]  ARADDR_i,
  input  logic         ARVALID_i,
  input  logic [3:0]   ARID_i,
  output logic         ARREADY_o,
  // read data channel
  output logic         RVALID_o,
  output logic [127:0] RDATA_o,
  output logic         RLAST_o,
  output logic [1:0]   RRESP_o,
  output logic [3:0]   RID_o,
  output logic [3:0]   RLEN_o,
  output logic [2:0]   RSIZE_o,
  input  logic         RREADY_i
);

  localparam logic [3:0] LAST_BEAT  = 4'(RD_BEATS - 1);
  localparam logic [2:0] WORD_SIZE  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;
  localparam logic [1:0] RESP_DEC   = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  logic [31:0] r_mem [16];

  // write side state
  wr_state_t   r_wstate;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;
  logic [3:0]  r_widx;
  logic        r_whit;
  logic        r_decerr;
  logic        r_slverr;

  // read side state
  rd_state_t   r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_rlast;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic [3:0]  r_rlen;
  logic [2:0]  r_rsize;
  logic [3:0]  r_ridx;
  logic        r_rhit;
  logic [3:0]  r_beat;

  logic        w_aw_hit;
  logic        w_ar_hit;
  logic        w_w_fire;
  logic        w_size_ok;
  logic        w_we;
  logic        w_decerr_n;
  logic        w_slverr_n;
  logic [3:0]  w_ridx_next;
  logic        w_unused;

  assign w_aw_hit    = (AWADDR_i[31:6] == BASE_ADDR[31:6]);
  assign w_ar_hit    = (ARADDR_i[31:6] == BASE_ADDR[31:6]);
  assign w_w_fire    = (r_wstate == W_DATA) && r_wready && WVALID_i;
  assign w_size_ok   = (WSIZE_i == WORD_SIZE);
  assign w_we        = w_w_fire && r_whit && w_size_ok;
  assign w_decerr_n  = r_decerr | ~r_whit;
  assign w_slverr_n  = r_slverr | ~w_size_ok;
  assign w_ridx_next = r_ridx + 4'd1;
  // burst length comes from RD_BEATS / WLAST; byte lane bits are truncated
  assign w_unused    = ^{WLEN_i, AWADDR_i[1:0], ARADDR_i[1:0]};

  // Memory: read side samples r_mem on the same edge, so a colliding
  // write and read-data load returns the old word.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_we) begin
      r_mem[r_widx] <= WDATA_i;
    end
  end

  // Write FSM
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bid     <= 4'd0;
      r_widx    <= 4'd0;
      r_whit    <= 1'b0;
      r_decerr  <= 1'b0;
      r_slverr  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (AWVALID_i && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_widx    <= AWADDR_i[5:2];
            r_bid     <= AWID_i;
            r_whit    <= w_aw_hit;
            r_decerr  <= 1'b0;
            r_slverr  <= 1'b0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            r_widx   <= r_widx + 4'd1;
            r_decerr <= w_decerr_n;
            r_slverr <= w_slverr_n;
            if (WLAST_i) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_decerr_n ? RESP_DEC :
                          (w_slverr_n ? RESP_SLV : RESP_OKAY);
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY_i) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rid     <= 4'd0;
      r_rlen    <= 4'd0;
      r_rsize   <= 3'b000;
      r_ridx    <= 4'd0;
      r_rhit    <= 1'b0;
      r_beat    <= 4'd0;
    end else begin
      r_rlen  <= LAST_BEAT;
      r_rsize <= WORD_SIZE;
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (ARVALID_i && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= ARID_i;
            r_ridx    <= ARADDR_i[5:2];
            r_rhit    <= w_ar_hit;
            r_beat    <= 4'd0;
            r_rdata   <= w_ar_hit ? r_mem[ARADDR_i[5:2]] : 32'd0;
            r_rlast   <= (LAST_BEAT == 4'd0);
            r_rresp   <= w_ar_hit ? RESP_OKAY : RESP_DEC;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY_i) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_ridx  <= w_ridx_next;
              r_rdata <= r_rhit ? r_mem[w_ridx_next] : 32'd0;
              r_rlast <= ((r_beat + 4'd1) == LAST_BEAT);
            end
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  assign AWREADY_o = r_awready;
  assign WREADY_o  = r_wready;
  assign BVALID_o  = r_bvalid;
  assign BRESP_o   = r_bresp;
  assign BID_o     = r_bid;
  assign ARREADY_o = r_arready;
  assign RVALID_o  = r_rvalid;
  assign RDATA_o   = {96'd0, r_rdata};
  assign RLAST_o   = r_rlast;
  assign RRESP_o   = r_rresp;
  assign RID_o     = r_rid;
  assign RLEN_o    = r_rlen;
  assign RSIZE_o   = r_rsize;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: write/read bursts, decode misses, wrap,
// bad size, back-pressure, same-word collision and reset mid-burst.
module tb_axi_slave_mem;

  logic         clk = 1'b0;
  logic         ARESET_i;
  logic [31:0]  AWADDR_i;
  logic         AWVALID_i;
  logic [3:0]   AWID_i;
  logic         AWREADY_o;
  logic [31:0]  WDATA_i;
  logic         WVALID_i;
  logic         WLAST_i;
  logic [3:0]   WLEN_i;
  logic [2:0]   WSIZE_i;
  logic         WREADY_o;
  logic         BVALID_o;
  logic [1:0]   BRESP_o;
  logic [3:0]   BID_o;
  logic         BREADY_i;
  logic [31:0]  ARADDR_i;
  logic         ARVALID_i;
  logic [3:0]   ARID_i;
  logic         ARREADY_o;
  logic         RVALID_o;
  logic [127:0] RDATA_o;
  logic         RLAST_o;
  logic [1:0]   RRESP_o;
  logic [3:0]   RID_o;
  logic [3:0]   RLEN_o;
  logic [2:0]   RSIZE_o;
  logic         RREADY_i;

  int n_tests = 0;
  int n_fail  = 0;

  axi_slave_mem #(.BASE_ADDR(32'h1010_1000), .RD_BEATS(4)) dut (
    .ACLK_i(clk), .ARESET_i(ARESET_i),
    .AWADDR_i(AWADDR_i), .AWVALID_i(AWVALID_i), .AWID_i(AWID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WVALID_i(WVALID_i), .WLAST_i(WLAST_i), .WLEN_i(WLEN_i),
    .WSIZE_i(WSIZE_i), .WREADY_o(WREADY_o),
    .BVALID_o(BVALID_o), .BRESP_o(BRESP_o), .BID_o(BID_o), .BREADY_i(BREADY_i),
    .ARADDR_i(ARADDR_i), .ARVALID_i(ARVALID_i), .ARID_i(ARID_i), .ARREADY_o(ARREADY_o),
    .RVALID_o(RVALID_o), .RDATA_o(RDATA_o), .RLAST_o(RLAST_o), .RRESP_o(RRESP_o),
    .RID_o(RID_o), .RLEN_o(RLEN_o), .RSIZE_o(RSIZE_o), .RREADY_i(RREADY_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {AWREADY_o, WREADY_o, BVALID_o, BRESP_o, BID_o, ARREADY_o,
                            RVALID_o, RLAST_o, RRESP_o, RID_o, RLEN_o, RSIZE_o}, 128'd0);
    check_eq({tag, "_rdata"}, RDATA_o, 128'd0);
  endtask

  task automatic aw_accept(input logic [31:0] addr, input logic [3:0] id);
    int cnt;
    AWADDR_i = addr; AWID_i = id; AWVALID_i = 1'b1;
    cnt = 0;
    while (!AWREADY_o && cnt < 20) begin
      tick();
      cnt++;
    end
    check_eq("aw_ready", AWREADY_o, 1);
    tick();
    AWVALID_i = 1'b0;
    check_eq("aw_done_awready", AWREADY_o, 0);
    check_eq("aw_done_wready", WREADY_o, 1);
  endtask

  // data beat i is data[32*i +: 32]; bad[i] sends that beat with WSIZE 3'b001
  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] id,
                          input logic [127:0] data, input int n,
                          input logic [3:0] bad, input logic [1:0] exp_resp);
    aw_accept(addr, id);
    for (int i = 0; i < n; i++) begin
      WDATA_i  = data[32*i +: 32];
      WSIZE_i  = bad[i] ? 3'b001 : 3'b010;
      WLAST_i  = (i == n - 1);
      WVALID_i = 1'b1;
      tick();
    end
    WVALID_i = 1'b0; WLAST_i = 1'b0;
    check_eq("b_valid", BVALID_o, 1);
    check_eq("b_id", BID_o, id);
    check_eq("b_resp", BRESP_o, exp_resp);
    $display("[TB] write addr=%08h id=%0d beats=%0d bresp=%0d", addr, id, n, BRESP_o);
    BREADY_i = 1'b1;
    tick();
    BREADY_i = 1'b0;
    check_eq("b_done_bvalid", BVALID_o, 0);
    check_eq("b_done_awready", AWREADY_o, 1);
  endtask

  // four-beat read with RREADY held high; e0..e3 are the expected words
  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] id,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3,
                          input logic [1:0] exp_resp);
    logic [127:0] exp_words;
    int cnt;
    exp_words = {e3, e2, e1, e0};
    ARADDR_i = addr; ARID_i = id; ARVALID_i = 1'b1; RREADY_i = 1'b1;
    cnt = 0;
    while (!ARREADY_o && cnt < 20) begin
      tick();
      cnt++;
    end
    check_eq("ar_ready", ARREADY_o, 1);
    tick();
    ARVALID_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check_eq("r_valid", RVALID_o, 1);
      check_eq("r_data", RDATA_o, {96'd0, exp_words[32*b +: 32]});
      check_eq("r_last", RLAST_o, (b == 3));
      check_eq("r_id", RID_o, id);
      check_eq("r_resp", RRESP_o, exp_resp);
      tick();
    end
    RREADY_i = 1'b0;
    check_eq("r_done_rvalid", RVALID_o, 0);
    $display("[TB] read  addr=%08h id=%0d beats=4 rresp=%0d", addr, id, exp_resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET_i = 1'b1;
    AWADDR_i = '0; AWVALID_i = 1'b0; AWID_i = '0;
    WDATA_i = '0; WVALID_i = 1'b0; WLAST_i = 1'b0; WLEN_i = 4'd3; WSIZE_i = 3'b010;
    BREADY_i = 1'b0;
    ARADDR_i = '0; ARVALID_i = 1'b0; ARID_i = '0; RREADY_i = 1'b0;

    tick(); tick();
    check_all_zero("reset");
    ARESET_i = 1'b0;
    tick();
    check_eq("post_rst_awready", AWREADY_o, 1);
    check_eq("post_rst_arready", ARREADY_o, 1);
    check_eq("rlen", RLEN_o, 4'd3);
    check_eq("rsize", RSIZE_o, 3'b010);

    // write burst + read-back
    wr_burst(32'h1010_1010, 4'd4, {32'hABCDEF77, 32'hABCDEF6C, 32'h0EFDAB8C, 32'h7FEABAAC},
             4, 4'b0000, 2'b00);
    rd_burst(32'h1010_1010, 4'd2, 32'h7FEABAAC, 32'h0EFDAB8C, 32'hABCDEF6C, 32'hABCDEF77, 2'b00);

    // decode misses
    rd_burst(32'hBCED_F123, 4'd1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b11);
    wr_burst(32'h2000_0000, 4'd9, {96'd0, 32'hDEADBEEF}, 1, 4'b0000, 2'b11);
    rd_burst(32'h1010_1000, 4'd3, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);

    // wrap inside the window
    wr_burst(32'h1010_1038, 4'd7, {32'hA0A0_0004, 32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001},
             4, 4'b0000, 2'b00);
    rd_burst(32'h1010_1038, 4'd7, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004, 2'b00);
    rd_burst(32'h1010_1000, 4'd8, 32'hA0A0_0003, 32'hA0A0_0004, 32'd0, 32'd0, 2'b00);

    // bad size on the second beat
    wr_burst(32'h1010_1020, 4'd5, {64'd0, 32'h1234_5678, 32'h5555_AAAA}, 2, 4'b0010, 2'b10);
    rd_burst(32'h1010_1020, 4'd5, 32'h5555_AAAA, 32'd0, 32'd0, 32'd0, 2'b00);

    // read back-pressure, unaligned address truncates to word 4
    ARADDR_i = 32'h1010_1013; ARID_i = 4'd11; ARVALID_i = 1'b1; RREADY_i = 1'b0;
    tick();
    ARVALID_i = 1'b0;
    check_eq("bp_beat0", RDATA_o, {96'd0, 32'h7FEABAAC});
    RREADY_i = 1'b1;
    tick();
    RREADY_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_rvalid", RVALID_o, 1);
      check_eq("bp_hold_rdata", RDATA_o, {96'd0, 32'h0EFDAB8C});
      check_eq("bp_hold_rlast", RLAST_o, 0);
    end
    RREADY_i = 1'b1;
    tick();
    check_eq("bp_beat2", RDATA_o, {96'd0, 32'hABCDEF6C});
    tick();
    check_eq("bp_beat3", RDATA_o, {96'd0, 32'hABCDEF77});
    check_eq("bp_beat3_last", RLAST_o, 1);
    tick();
    RREADY_i = 1'b0;
    check_eq("bp_done_rvalid", RVALID_o, 0);
    $display("[TB] read  addr=10101013 id=11 beats=4 with 5-cycle stall");

    // write response back-pressure blocks the next AW
    aw_accept(32'h1010_1000, 4'd6);
    WDATA_i = 32'hCAFE_F00D; WSIZE_i = 3'b010; WLAST_i = 1'b1; WVALID_i = 1'b1;
    tick();
    WVALID_i = 1'b0; WLAST_i = 1'b0;
    AWADDR_i = 32'h1010_1004; AWID_i = 4'd12; AWVALID_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bhold_bvalid", BVALID_o, 1);
      check_eq("bhold_bid", BID_o, 4'd6);
      check_eq("bhold_awready", AWREADY_o, 0);
      check_eq("bhold_wready", WREADY_o, 0);
    end
    AWVALID_i = 1'b0;
    BREADY_i = 1'b1;
    tick();
    BREADY_i = 1'b0;
    check_eq("bhold_release_bvalid", BVALID_o, 0);
    check_eq("bhold_release_awready", AWREADY_o, 1);
    $display("[TB] write addr=10101000 id=6 beats=1 with B stall");

    // same-word collision: read load sees the old word
    aw_accept(32'h1010_1000, 4'd13);
    WDATA_i = 32'h1111_2222; WSIZE_i = 3'b010; WLAST_i = 1'b1; WVALID_i = 1'b1;
    ARADDR_i = 32'h1010_1000; ARID_i = 4'd14; ARVALID_i = 1'b1; RREADY_i = 1'b0;
    tick();
    WVALID_i = 1'b0; WLAST_i = 1'b0; ARVALID_i = 1'b0;
    check_eq("coll_rdata_old", RDATA_o, {96'd0, 32'hCAFE_F00D});
    check_eq("coll_bvalid", BVALID_o, 1);
    BREADY_i = 1'b1; RREADY_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    BREADY_i = 1'b0; RREADY_i = 1'b0;
    check_eq("coll_done_rvalid", RVALID_o, 0);
    check_eq("coll_done_bvalid", BVALID_o, 0);
    $display("[TB] collision write+read word 0");
    rd_burst(32'h1010_1000, 4'd15, 32'h1111_2222, 32'hA0A0_0004, 32'd0, 32'd0, 2'b00);

    // reset mid-burst
    aw_accept(32'h1010_1000, 4'd1);
    WSIZE_i = 3'b010; WLAST_i = 1'b0; WVALID_i = 1'b1;
    WDATA_i = 32'hBAD0_0001; tick();
    WDATA_i = 32'hBAD0_0002; tick();
    WVALID_i = 1'b0;
    ARESET_i = 1'b1;
    tick();
    check_all_zero("midrst");
    ARESET_i = 1'b0;
    tick();
    check_eq("midrst_awready", AWREADY_o, 1);
    check_eq("midrst_bvalid", BVALID_o, 0);
    $display("[TB] reset during write burst");
    wr_burst(32'h1010_1010, 4'd3, {32'h0000_0404, 32'h0000_0303, 32'h0000_0202, 32'h0000_0101},
             4, 4'b0000, 2'b00);
    rd_burst(32'h1010_1000, 4'd4, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00);
    rd_burst(32'h1010_1010, 4'd5, 32'h0000_0101, 32'h0000_0202, 32'h0000_0303, 32'h0000_0404, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI-style responder (slave) that terminates the write-address, write-data, write-response, read-address and read-data channels driven by the team's `axi_master`. It backs a 16-word × 32-bit register memory at a fixed base address. It accepts one write burst and one read burst at a time, each handled by an independent FSM. It returns OKAY, SLVERR or DECERR responses tagged with the request ID.

## Interface
- `BASE_ADDR`, 32'h1010_1000: byte base of memory window; window size is 64 bytes.
- `RD_BEATS`, 4: beats per read burst (1..16).
- `ACLK_i` in 1: single clock, all logic on rising edge.
- `ARESET_i` in 1: reset, synchronous and active-high.
- `AWADDR_i` in 32, `AWVALID_i` in 1, `AWID_i` in 4: write address channel.
- `AWREADY_o` out 1: write address accepted.
- `WDATA_i` in 32, `WVALID_i` in 1, `WLAST_i` in 1, `WLEN_i` in 4, `WSIZE_i` in 3: write data channel; `WLEN_i` is ignored.
- `WREADY_o` out 1: write beat accepted.
- `BVALID_o` out 1, `BRESP_o` out 2, `BID_o` out 4: write response channel.
- `BREADY_i` in 1: master accepts the write response.
- `ARADDR_i` in 32, `ARVALID_i` in 1, `ARID_i` in 4: read address channel.
- `ARREADY_o` out 1: read address accepted.
- `RVALID_o` out 1, `RDATA_o` out 128, `RLAST_o` out 1, `RRESP_o` out 2, `RID_o` out 4, `RLEN_o` out 4, `RSIZE_o` out 3: read data channel.
- `RREADY_i` in 1: master accepts the read beat.

## Operation
- **Decode.** An address hits when `addr[31:6] == BASE_ADDR[31:6]`. Word index is `addr[5:2]`; `addr[1:0]` is ignored, so unaligned addresses are truncated.
- **Index wrap.** The word index increments by 1 per beat, modulo 16, with wrap-around inside the window.
- **Write FSM: W_IDLE.** `AWREADY_o`=1. On AW handshake, latch index, ID and hit flag, then go to W_DATA.
- **Write FSM: W_DATA.** `WREADY_o`=1. Each W handshake writes `WDATA_i` to `mem[idx]` and increments idx.
  - The write is suppressed on a miss or when `WSIZE_i != 3'b010`.
  - A sticky error flag records a miss (DECERR) or any bad size (SLVERR).
  - A handshake with `WLAST_i`=1 moves to W_RESP.
- **Write FSM: W_RESP.** `BVALID_o`=1, `BID_o` = latched ID.
  - `BRESP_o` is 2'b00 (OKAY), 2'b10 (SLVERR) or 2'b11 (DECERR). DECERR has priority over SLVERR.
  - Hold until `BREADY_i`=1, then return to W_IDLE.
- **Read FSM: R_IDLE.** `ARREADY_o`=1. On AR handshake:
  - latch ID, index and hit flag;
  - clear the beat counter;
  - load `RDATA_o` with `{96'd0, hit ? mem[idx] : 32'd0}`;
  - go to R_DATA.
- **Read FSM: R_DATA.** `RVALID_o`=1.
  - `RLAST_o` = (beat == `RD_BEATS`-1).
  - `RRESP_o` is 2'b00 on a hit, 2'b11 on a miss.
  - On `RREADY_i`: if last, return to R_IDLE; otherwise increment beat and idx, and register the next word.
- **Static read fields.** `RLEN_o` = `RD_BEATS`-1. `RSIZE_o` = 3'b010.
- **Channel independence.** Write and read FSMs run concurrently.
- **Same-word collision.** `RDATA_o` is registered, so a write and a read-data load to the same word in the same cycle returns the old word.
- **Reset.** Reset clears memory to 0 and both FSMs to IDLE. Reset mid-burst aborts the burst: no B response is issued, and partial writes already committed remain until the reset cycle clears memory.

## Timing
- **Output reset values.** While `ARESET_i`=1, all outputs are 0: `AWREADY_o`, `WREADY_o`, `BVALID_o`, `ARREADY_o`, `RVALID_o`, `RLAST_o`, and all data, ID, response, `RLEN_o` and `RSIZE_o` fields.
- **Ready after reset.** `AWREADY_o` and `ARREADY_o` go to 1 the first cycle after reset deasserts.
- **AW to W.** AW handshake at edge N gives `AWREADY_o`=0 and `WREADY_o`=1 from cycle N+1.
- **W to B.** Last W handshake at edge M gives `BVALID_o`=1 from cycle M+1. The earliest next AW accept is the cycle after B completes.
- **AR to R.** AR handshake at edge N gives `RVALID_o`=1 with the first beat's data in cycle N+1.
- **Read throughput.** With `RREADY_i` held high, one beat per cycle; a burst takes `RD_BEATS` cycles.
- **Handshake rules.**
  - `BVALID_o` and `RVALID_o`, once asserted, stay asserted with stable payload until the handshake; `RREADY_i` low stalls indefinitely.
  - The slave never drops VALID without a handshake, except on reset.
- **Master-side latency.** `BREADY_i` or `RREADY_i` arriving one cycle after VALID (master behaviour) is legal. Each handshake completes on the first edge where both are high.

## Test plan
- **Write burst.** AW 0x10101010, ID 4; W beats 0x7FEABAAC, 0x0EFDAB8C, 0xABCDEF6C, 0xABCDEF77 (last with WLAST, WSIZE 3'b010).
  - Required: `mem[4..7]` hold these values.
  - Required: `BVALID_o`=1 one cycle after the last beat, `BID_o`=4, `BRESP_o`=00.
- **Read-back.** AR 0x10101010, ID 2, `RREADY_i` high.
  - Required: 4 beats with `RDATA_o[31:0]` = the four written words in order, `RLAST_o` on beat 4 only, `RID_o`=2, `RRESP_o`=00.
- **Decode miss.** AR 0xBCEDF123: 4 beats, data 0, `RRESP_o`=11.
  - AW 0x20000000 with a 1-beat write: `BRESP_o`=11, memory unchanged.
- **Wrap and bad size.** Write 4 beats at 0x1010_1038; required: words land in `mem[14]`, `mem[15]`, `mem[0]`, `mem[1]`.
  - A write beat with `WSIZE_i`=3'b001 gives `BRESP_o`=10 and that word is not written.
- **Back-pressure.** Hold `RREADY_i`=0 for 5 cycles mid-burst; required: `RVALID_o`, `RDATA_o` and `RLAST_o` stay stable.
  - Hold `BREADY_i`=0; required: `BVALID_o` held and no new AW accepted.
- **Reset mid-burst.** Assert `ARESET_i` after 2 W beats; required: next cycle all outputs 0, memory 0.
  - After release: `AWREADY_o`=1, and a fresh burst completes with OKAY.
